// File: rtl/prime_pkg.sv
// Shared definitions for the prime sequencer: default data width and FSM states.
package prime_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/prime_sequencer_if.sv
// Bundle of the candidate, verdict and divider handshakes of the prime sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface prime_sequencer_if
    import prime_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             valid_i;
    logic             ready_i;
    logic [WIDTH-1:0] n_i;

    logic             valid_o;
    logic             ready_o;
    logic             is_prime_o;
    logic [WIDTH-1:0] div_count_o;

    logic             mod_valid;
    logic             mod_ready;
    logic [WIDTH-1:0] mod_a;
    logic [WIDTH-1:0] mod_b;
    logic             mod_zero;
    logic             mod_done;
    logic             mod_accept;

    modport slave (
        input  valid_i, n_i, ready_o, mod_ready, mod_zero, mod_done,
        output ready_i, valid_o, is_prime_o, div_count_o,
               mod_valid, mod_a, mod_b, mod_accept
    );

    modport master (
        output valid_i, n_i, ready_o, mod_ready, mod_zero, mod_done,
        input  ready_i, valid_o, is_prime_o, div_count_o,
               mod_valid, mod_a, mod_b, mod_accept
    );

endinterface

// File: rtl/square_step.sv
// Trial divisor d and its square sq, advanced incrementally without a multiplier:
// (d+1)^2 = d^2 + 2d + 1. Also reports whether the advanced square exceeds N,
// which is the point where no further trial division can find a factor.
module square_step
    import prime_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_init,
    input  logic             i_advance,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_d,
    output logic             o_next_gt_n
);

    // sq carries 2*WIDTH+1 bits so the square never wraps even at the last step
    localparam int SQ_W = 2 * WIDTH + 1;

    logic [WIDTH-1:0] r_d;
    logic [SQ_W-1:0]  r_sq;
    logic [SQ_W-1:0]  w_sq_adv;

    // {d,1} is 2d+1 using the current (old) d
    assign w_sq_adv    = r_sq + SQ_W'({r_d, 1'b1});
    assign o_next_gt_n = w_sq_adv > SQ_W'(i_n);
    assign o_d         = r_d;

    // Divisor/square registers: start at 2/4 for a new candidate, step on each non-zero remainder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d  <= '0;
            r_sq <= '0;
        end else if (i_init) begin
            r_d  <= WIDTH'(2);
            r_sq <= SQ_W'(4);
        end else if (i_advance) begin
            r_d  <= r_d + WIDTH'(1);
            r_sq <= w_sq_adv;
        end
    end

endmodule

// File: rtl/prime_sequencer.sv
// Trial-division primality sequencer. Accepts a candidate N, issues N mod d
// requests to an external divider for d = 2, 3, ... while d*d <= N, and reports
// a verdict plus the number of divisions issued. Stops at the first zero remainder.
module prime_sequencer
    import prime_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic              clk,
    input logic              rst_n,
    prime_sequencer_if.slave bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_count;
    logic             r_is_prime;

    logic [WIDTH-1:0] w_d;
    logic             w_gt;
    logic             w_ready_i;
    logic             w_valid_o;
    logic             w_mod_valid;
    logic             w_mod_accept;
    logic             w_init;
    logic             w_advance;
    logic             w_issue_xfer;
    logic             w_result_xfer;

    square_step #(
        .WIDTH(WIDTH)
    ) u_square_step (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_init      (w_init),
        .i_advance   (w_advance),
        .i_n         (r_n),
        .o_d         (w_d),
        .o_next_gt_n (w_gt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-state handshake outputs; results from the divider only count in WAIT
    always_comb begin
        w_state_next  = r_state;
        w_ready_i     = 1'b0;
        w_valid_o     = 1'b0;
        w_mod_valid   = 1'b0;
        w_mod_accept  = 1'b0;
        w_init        = 1'b0;
        w_advance     = 1'b0;
        w_issue_xfer  = 1'b0;
        w_result_xfer = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready_i = 1'b1;
                if (bus.valid_i) begin
                    w_init       = 1'b1;
                    // 0..3 are decided without any division
                    w_state_next = (bus.n_i < WIDTH'(4)) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_mod_valid = 1'b1;
                if (bus.mod_ready) begin
                    w_issue_xfer = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_mod_accept = 1'b1;
                if (bus.mod_done) begin
                    w_result_xfer = 1'b1;
                    if (bus.mod_zero) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = w_gt ? ST_DONE : ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                w_valid_o = 1'b1;
                if (bus.ready_o) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Candidate, division count and verdict registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n        <= '0;
            r_count    <= '0;
            r_is_prime <= 1'b0;
        end else begin
            if (w_init) begin
                r_n        <= bus.n_i;
                r_count    <= '0;
                // Only meaningful for N<4; larger N are resolved by the division loop
                r_is_prime <= (bus.n_i == WIDTH'(2)) || (bus.n_i == WIDTH'(3));
            end
            if (w_issue_xfer) begin
                r_count <= r_count + WIDTH'(1);
            end
            if (w_result_xfer) begin
                if (bus.mod_zero) begin
                    r_is_prime <= 1'b0;
                end else if (w_gt) begin
                    r_is_prime <= 1'b1;
                end
            end
        end
    end

    assign bus.ready_i     = w_ready_i;
    assign bus.valid_o     = w_valid_o;
    assign bus.is_prime_o  = r_is_prime;
    assign bus.div_count_o = r_count;
    assign bus.mod_valid   = w_mod_valid;
    assign bus.mod_accept  = w_mod_accept;
    assign bus.mod_a       = r_n;
    assign bus.mod_b       = w_d;

endmodule

// File: tb/tb_prime_sequencer.sv
// Bench for prime_sequencer: drives candidates, models the divider, and compares
// verdicts, division counts and the issued divisor sequence with a reference model.
module tb_prime_sequencer;
    import prime_pkg::*;

    localparam int W      = WIDTH_DEF;
    localparam int BUDGET = 5000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    prime_sequencer_if #(.WIDTH(W)) bus ();

    prime_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int exp_div[$];
    bit exp_prime;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Trial division straight from the definition: every d with d*d <= N is tried until one divides N
    task automatic ref_model(input int n);
        exp_div.delete();
        exp_prime = (n >= 2);
        for (int d = 2; d * d <= n; d++) begin
            exp_div.push_back(d);
            if (n % d == 0) begin
                exp_prime = 1'b0;
                break;
            end
        end
    endtask

    task automatic present(input int n);
        int k;
        @(negedge clk);
        k = 0;
        while (k < 20 && bus.ready_i !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        check_eq("ready_i_idle", bus.ready_i, 1);
        bus.valid_i = 1'b1;
        bus.n_i     = W'(n);
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.n_i     = W'($urandom);
    endtask

    task automatic do_candidate(input int n, input bit stall_out, input bit stall_mod);
        int         cyc;
        int         idx;
        int         div_wait;
        int         prev_b;
        int         mod_stall;
        int         out_hold;
        bit         done;
        bit         got_verdict;
        bit         div_busy;
        bit         div_zero;
        bit         prev_mod_xfer;
        bit         prev_res_xfer;
        bit         prev_out_xfer;
        logic       snap_prime;
        logic [W-1:0] snap_cnt;
        idx = 0; div_wait = 0; prev_b = 0; mod_stall = 0; out_hold = 0;
        done = 0; got_verdict = 0; div_busy = 0; div_zero = 0;
        prev_mod_xfer = 0; prev_res_xfer = 0; prev_out_xfer = 0;
        snap_prime = 1'b0; snap_cnt = '0;
        ref_model(n);
        present(n);
        cyc = 1;
        while (!done && cyc <= BUDGET) begin
            // Apply what the previous rising edge transferred
            if (prev_res_xfer) div_busy = 0;
            if (prev_mod_xfer) begin
                div_busy = 1;
                div_wait = $urandom_range(0, 3);
                div_zero = (prev_b == 0) ? 1'b1 : ((n % prev_b) == 0);
                idx++;
            end
            if (prev_out_xfer) begin
                check_eq("idle_ready_i", bus.ready_i, 1);
                check_eq("idle_valid_o", bus.valid_o, 0);
                check_eq("divisions_total", idx, exp_div.size());
                done = 1;
            end else begin
                check_eq("busy_ready_i", bus.ready_i, 0);
                if (bus.mod_valid === 1'b1) begin
                    if (idx < exp_div.size()) begin
                        check_eq("mod_a", bus.mod_a, n);
                        check_eq("mod_b", bus.mod_b, exp_div[idx]);
                    end else begin
                        check_eq("extra_div", 1, 0);
                    end
                end
                // Divider ready side
                if (bus.mod_valid === 1'b1 && stall_mod && mod_stall < 3) begin
                    bus.mod_ready = 1'b0;
                    mod_stall++;
                end else begin
                    bus.mod_ready = ($urandom_range(0, 3) != 0);
                end
                // Divider result side; stray done pulses outside WAIT must be ignored
                if (div_busy) begin
                    check_eq("wait_mod_accept", bus.mod_accept, 1);
                    if (div_wait > 0) begin
                        div_wait--;
                        bus.mod_done = 1'b0;
                        bus.mod_zero = $urandom_range(0, 1);
                    end else begin
                        bus.mod_done = 1'b1;
                        bus.mod_zero = div_zero;
                    end
                end else begin
                    bus.mod_done = (bus.mod_valid === 1'b1) && ($urandom_range(0, 3) == 0);
                    bus.mod_zero = 1'b1;
                end
                // Verdict side
                if (bus.valid_o === 1'b1) begin
                    if (!got_verdict) begin
                        got_verdict = 1;
                        check_eq("is_prime", bus.is_prime_o, exp_prime);
                        check_eq("div_count", bus.div_count_o, exp_div.size());
                        if (n < 4) check_eq("latency", cyc, 1);
                        snap_prime = bus.is_prime_o;
                        snap_cnt   = bus.div_count_o;
                        $display("cand N=%0d prime=%0d divisions=%0d cycles=%0d",
                                 n, bus.is_prime_o, bus.div_count_o, cyc);
                    end else begin
                        check_eq("hold_is_prime", bus.is_prime_o, snap_prime);
                        check_eq("hold_div_count", bus.div_count_o, snap_cnt);
                    end
                    check_eq("done_mod_valid", bus.mod_valid, 0);
                end
                if (bus.valid_o === 1'b1 && stall_out && out_hold < 5) begin
                    bus.ready_o = 1'b0;
                    out_hold++;
                end else begin
                    bus.ready_o = ($urandom_range(0, 2) != 0);
                end
                prev_mod_xfer = (bus.mod_valid === 1'b1) && bus.mod_ready;
                prev_b        = int'(bus.mod_b);
                prev_res_xfer = (bus.mod_accept === 1'b1) && bus.mod_done;
                prev_out_xfer = (bus.valid_o === 1'b1) && bus.ready_o;
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) check_eq("verdict_timeout", 0, 1);
        if (stall_out) check_eq("out_stall_seen", out_hold, 5);
        bus.ready_o   = 1'b0;
        bus.mod_ready = 1'b0;
        bus.mod_done  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string where);
        check_eq({where, "_ready_i"}, bus.ready_i, 1);
        check_eq({where, "_valid_o"}, bus.valid_o, 0);
        check_eq({where, "_mod_valid"}, bus.mod_valid, 0);
        check_eq({where, "_mod_accept"}, bus.mod_accept, 0);
        check_eq({where, "_is_prime"}, bus.is_prime_o, 0);
        check_eq({where, "_div_count"}, bus.div_count_o, 0);
        check_eq({where, "_mod_a"}, bus.mod_a, 0);
        check_eq({where, "_mod_b"}, bus.mod_b, 0);
    endtask

    task automatic reset_mid_wait();
        int  k;
        bit  in_wait;
        present(97);
        in_wait = 0;
        k = 0;
        while (k < 50 && !in_wait) begin
            if (bus.mod_accept === 1'b1) begin
                in_wait = 1;
            end else begin
                bus.mod_ready = 1'b1;
                bus.mod_done  = 1'b0;
                @(negedge clk);
                k++;
            end
        end
        check_eq("reached_wait", in_wait, 1);
        // Pulse reset between edges: the return to IDLE must not wait for a clock
        #2 rst_n = 1'b0;
        #1;
        $display("reset asserted during WAIT for N=97");
        check_reset_outputs("async_rst");
        bus.mod_ready = 1'b0;
        bus.mod_done  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check_eq("post_rst_valid_o", bus.valid_o, 0);
            check_eq("post_rst_ready_i", bus.ready_i, 1);
        end
    endtask

    initial begin
        int n;
        bus.valid_i   = 1'b0;
        bus.n_i       = '0;
        bus.ready_o   = 1'b0;
        bus.mod_ready = 1'b0;
        bus.mod_zero  = 1'b0;
        bus.mod_done  = 1'b0;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_candidate(0, 0, 0);
        do_candidate(1, 0, 0);
        do_candidate(2, 0, 0);
        do_candidate(3, 0, 0);
        do_candidate(4, 0, 0);
        do_candidate(25, 0, 0);
        do_candidate(97, 0, 0);
        do_candidate(91, 0, 0);
        do_candidate(65521, 0, 0);
        do_candidate(65535, 0, 0);
        do_candidate(97, 1, 1);
        reset_mid_wait();
        do_candidate(91, 0, 0);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) n = $urandom_range(0, 20);
            else                           n = $urandom_range(0, 3000);
            do_candidate(n, $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
